// File: rtl/ultrasonido_emulador.sv
// rtl/ultrasonido_emulador.sv - HC-SR04 sensor-side emulator: trigger qualification, burst delay, distance-coded echo
module ultrasonido_emulador #(
  parameter int unsigned T_TRIG_MIN     = 500,
  parameter int unsigned BURST_CYCLES   = 10000,
  parameter int unsigned CYC_POR_CM     = 2900,
  parameter int unsigned MAX_CM         = 400,
  parameter int unsigned TIMEOUT_CYCLES = 1900000,
  parameter int unsigned HOLDOFF_CYCLES = 50000
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       trigger,
  input  logic [8:0] distancia_cm,
  output logic       echo,
  output logic       busy,
  output logic       trig_corto,
  output logic       trig_ignorado
);

  localparam logic [2:0] ST_IDLE      = 3'd0;
  localparam logic [2:0] ST_TRIG_ALTO = 3'd1;
  localparam logic [2:0] ST_BURST     = 3'd2;
  localparam logic [2:0] ST_ECHO      = 3'd3;
  localparam logic [2:0] ST_HOLDOFF   = 3'd4;

  localparam logic [21:0] CNT_MAX    = '1;
  localparam logic [21:0] T_MIN_W    = 22'(T_TRIG_MIN);
  localparam logic [21:0] BURST_LAST = 22'(BURST_CYCLES - 1);
  localparam logic [21:0] HOLD_LAST  = 22'(HOLDOFF_CYCLES - 1);
  localparam logic [21:0] CYC_CM_W   = 22'(CYC_POR_CM);
  localparam logic [21:0] TIMEOUT_W  = 22'(TIMEOUT_CYCLES);
  localparam logic [8:0]  MAX_CM_W   = 9'(MAX_CM);

  logic        trig_meta_q, trig_meta_d;
  logic        trig_s_q, trig_s_d;
  logic        trig_prev_q, trig_prev_d;
  logic [2:0]  state_q, state_d;
  logic [21:0] cnt_q, cnt_d;
  logic [21:0] echo_len_q, echo_len_d;
  logic        echo_q, echo_d;
  logic        busy_q, busy_d;
  logic        trig_corto_q, trig_corto_d;
  logic        trig_ignorado_q, trig_ignorado_d;

  logic        trig_rise;
  logic [21:0] cnt_inc;
  logic [21:0] len_calc;
  logic        in_busy_state;

  // Next-state logic: synchronizer shift, FSM transitions, counter and echo length
  always_comb begin
    trig_meta_d     = trigger;
    trig_s_d        = trig_meta_q;
    trig_prev_d     = trig_s_q;
    state_d         = state_q;
    cnt_d           = cnt_q;
    echo_len_d      = echo_len_q;
    trig_corto_d    = 1'b0;
    trig_ignorado_d = 1'b0;

    trig_rise = trig_s_q & ~trig_prev_q;
    cnt_inc   = (cnt_q == CNT_MAX) ? cnt_q : cnt_q + 22'd1;
    // Out-of-range distances (0 or beyond the sensor range) report as "no target"
    if ((distancia_cm != 9'd0) && (distancia_cm <= MAX_CM_W)) begin
      len_calc = 22'(distancia_cm) * CYC_CM_W;
    end else begin
      len_calc = TIMEOUT_W;
    end
    in_busy_state = (state_q == ST_BURST) || (state_q == ST_ECHO) || (state_q == ST_HOLDOFF);

    case (state_q)
      ST_IDLE: begin
        if (trig_rise) begin
          state_d = ST_TRIG_ALTO;
          cnt_d   = 22'd1;
        end
      end
      ST_TRIG_ALTO: begin
        if (trig_s_q) begin
          cnt_d = cnt_inc;
        end else if (cnt_q >= T_MIN_W) begin
          echo_len_d = len_calc;
          cnt_d      = 22'd0;
          state_d    = ST_BURST;
        end else begin
          trig_corto_d = 1'b1;
          cnt_d        = 22'd0;
          state_d      = ST_IDLE;
        end
      end
      ST_BURST: begin
        if (cnt_q == BURST_LAST) begin
          cnt_d   = 22'd0;
          state_d = ST_ECHO;
        end else begin
          cnt_d = cnt_inc;
        end
      end
      ST_ECHO: begin
        if (cnt_q == echo_len_q - 22'd1) begin
          cnt_d   = 22'd0;
          state_d = ST_HOLDOFF;
        end else begin
          cnt_d = cnt_inc;
        end
      end
      ST_HOLDOFF: begin
        if (cnt_q == HOLD_LAST) begin
          cnt_d   = 22'd0;
          state_d = ST_IDLE;
        end else begin
          cnt_d = cnt_inc;
        end
      end
      default: begin
        cnt_d   = 22'd0;
        state_d = ST_IDLE;
      end
    endcase

    // Outputs follow the next state so they change on the same edge as the FSM
    if (trig_rise && in_busy_state) begin
      trig_ignorado_d = 1'b1;
    end
    echo_d = (state_d == ST_ECHO);
    busy_d = (state_d == ST_BURST) || (state_d == ST_ECHO) || (state_d == ST_HOLDOFF);
  end

  // State registers with asynchronous reset so echo drops the moment reset asserts
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      trig_meta_q     <= 1'b0;
      trig_s_q        <= 1'b0;
      trig_prev_q     <= 1'b0;
      state_q         <= ST_IDLE;
      cnt_q           <= 22'd0;
      echo_len_q      <= 22'd0;
      echo_q          <= 1'b0;
      busy_q          <= 1'b0;
      trig_corto_q    <= 1'b0;
      trig_ignorado_q <= 1'b0;
    end else begin
      trig_meta_q     <= trig_meta_d;
      trig_s_q        <= trig_s_d;
      trig_prev_q     <= trig_prev_d;
      state_q         <= state_d;
      cnt_q           <= cnt_d;
      echo_len_q      <= echo_len_d;
      echo_q          <= echo_d;
      busy_q          <= busy_d;
      trig_corto_q    <= trig_corto_d;
      trig_ignorado_q <= trig_ignorado_d;
    end
  end

  assign echo          = echo_q;
  assign busy          = busy_q;
  assign trig_corto    = trig_corto_q;
  assign trig_ignorado = trig_ignorado_q;

endmodule

// File: tb/tb_ultrasonido_emulador.sv
// tb/tb_ultrasonido_emulador.sv - directed self-checking bench for ultrasonido_emulador
module tb_ultrasonido_emulador;

  logic       clk = 1'b0;
  logic       reset = 1'b1;
  logic       trigger = 1'b0;
  logic [8:0] distancia_cm = 9'd0;
  logic       echo, busy, trig_corto, trig_ignorado;

  int total = 0;
  int bad = 0;

  ultrasonido_emulador #(
    .T_TRIG_MIN(10), .BURST_CYCLES(20), .CYC_POR_CM(4),
    .MAX_CM(400), .TIMEOUT_CYCLES(2000), .HOLDOFF_CYCLES(50)
  ) dut (
    .clk(clk), .reset(reset), .trigger(trigger), .distancia_cm(distancia_cm),
    .echo(echo), .busy(busy), .trig_corto(trig_corto), .trig_ignorado(trig_ignorado)
  );

  always #5 clk = ~clk;

  // Running tallies of output activity, sampled on the falling edge
  int cyc = 0, echo_hi = 0, busy_hi = 0, corto_n = 0, ign_n = 0, echo_rises = 0;
  int t_echo_rise = 0, t_busy_rise = 0;
  logic echo_prev = 1'b0, busy_prev = 1'b0;

  always @(negedge clk) begin
    cyc <= cyc + 1;
    if (echo) echo_hi <= echo_hi + 1;
    if (busy) busy_hi <= busy_hi + 1;
    if (trig_corto) corto_n <= corto_n + 1;
    if (trig_ignorado) ign_n <= ign_n + 1;
    if (echo && !echo_prev) begin
      echo_rises  <= echo_rises + 1;
      t_echo_rise <= cyc;
    end
    if (busy && !busy_prev) t_busy_rise <= cyc;
    echo_prev <= echo;
    busy_prev <= busy;
  end

  task automatic chk(input string tag, input int obs, input int exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  task automatic pulse(input int n);
    @(negedge clk);
    trigger = 1'b1;
    repeat (n) @(negedge clk);
    trigger = 1'b0;
  endtask

  task automatic wait_echo(input logic val, input int budget, output bit ok);
    ok = 1'b0;
    for (int i = 0; i < budget; i++) begin
      if (echo === val) begin
        ok = 1'b1;
        return;
      end
      @(negedge clk);
    end
  endtask

  task automatic wait_busy(input logic val, input int budget, output bit ok);
    ok = 1'b0;
    for (int i = 0; i < budget; i++) begin
      if (busy === val) begin
        ok = 1'b1;
        return;
      end
      @(negedge clk);
    end
  endtask

  // One full measurement: trigger pulse, then wait until busy has risen and fallen
  task automatic run_meas(input int hi, output int ew, output int bw, output int roff,
                          output int nr, output bit ok);
    int e0, b0, r0;
    bit ok1, ok2;
    e0 = echo_hi; b0 = busy_hi; r0 = echo_rises;
    pulse(hi);
    wait_busy(1'b1, 40, ok1);
    wait_busy(1'b0, 5000, ok2);
    ok   = ok1 && ok2;
    ew   = echo_hi - e0;
    bw   = busy_hi - b0;
    nr   = echo_rises - r0;
    roff = t_echo_rise - t_busy_rise;
  endtask

  int ew, bw, roff, nr, c0, i0, e0, b0, r0;
  bit ok;

  initial begin
    // Reset state
    repeat (3) @(negedge clk);
    chk("rst_echo", int'(echo), 0);
    chk("rst_busy", int'(busy), 0);
    chk("rst_corto", int'(trig_corto), 0);
    chk("rst_ign", int'(trig_ignorado), 0);
    reset = 1'b0;
    repeat (3) @(negedge clk);

    // 1: nominal measurement, 25 cm
    distancia_cm = 9'd25;
    c0 = corto_n; i0 = ign_n;
    run_meas(12, ew, bw, roff, nr, ok);
    chk("s1_done", int'(ok), 1);
    chk("s1_echo_width", ew, 100);
    chk("s1_busy_width", bw, 170);
    chk("s1_echo_offset", roff, 20);
    chk("s1_echo_pulses", nr, 1);
    chk("s1_corto", corto_n - c0, 0);
    chk("s1_ign", ign_n - i0, 0);
    repeat (5) @(negedge clk);

    // 2: short trigger, then boundary widths 9 and 10
    c0 = corto_n; e0 = echo_hi; b0 = busy_hi;
    pulse(5);
    repeat (10) @(negedge clk);
    chk("s2_corto", corto_n - c0, 1);
    chk("s2_echo", echo_hi - e0, 0);
    chk("s2_busy", busy_hi - b0, 0);
    c0 = corto_n;
    pulse(9);
    repeat (10) @(negedge clk);
    chk("s2_corto9", corto_n - c0, 1);
    distancia_cm = 9'd1;
    c0 = corto_n;
    run_meas(10, ew, bw, roff, nr, ok);
    chk("s2_min_done", int'(ok), 1);
    chk("s2_min_echo", ew, 4);
    chk("s2_min_busy", bw, 74);
    chk("s2_min_corto", corto_n - c0, 0);
    repeat (5) @(negedge clk);

    // 3: out-of-range distances time out, 400 cm is the last normal value
    distancia_cm = 9'd0;
    run_meas(12, ew, bw, roff, nr, ok);
    chk("s3_d0_done", int'(ok), 1);
    chk("s3_d0_echo", ew, 2000);
    repeat (5) @(negedge clk);
    distancia_cm = 9'd401;
    run_meas(12, ew, bw, roff, nr, ok);
    chk("s3_d401_done", int'(ok), 1);
    chk("s3_d401_echo", ew, 2000);
    repeat (5) @(negedge clk);
    distancia_cm = 9'd400;
    run_meas(12, ew, bw, roff, nr, ok);
    chk("s3_d400_done", int'(ok), 1);
    chk("s3_d400_echo", ew, 1600);
    repeat (5) @(negedge clk);

    // 4: retrigger during ECHO, then trigger held high across end of HOLDOFF
    distancia_cm = 9'd25;
    e0 = echo_hi; i0 = ign_n;
    pulse(12);
    wait_echo(1'b1, 100, ok);
    chk("s4_echo_up", int'(ok), 1);
    pulse(3);
    wait_echo(1'b0, 200, ok);
    chk("s4_echo_down", int'(ok), 1);
    chk("s4_ign_echo", ign_n - i0, 1);
    chk("s4_echo_width", echo_hi - e0, 100);
    i0 = ign_n;
    @(negedge clk);
    trigger = 1'b1;
    wait_busy(1'b0, 100, ok);
    chk("s4_idle", int'(ok), 1);
    chk("s4_ign_hold", ign_n - i0, 1);
    b0 = busy_hi; r0 = echo_rises;
    repeat (30) @(negedge clk);
    chk("s4_level_busy", busy_hi - b0, 0);
    chk("s4_level_echo", echo_rises - r0, 0);
    trigger = 1'b0;
    repeat (5) @(negedge clk);
    run_meas(12, ew, bw, roff, nr, ok);
    chk("s4_next_done", int'(ok), 1);
    chk("s4_next_echo", ew, 100);
    repeat (5) @(negedge clk);

    // 5: distance change after latch has no effect
    distancia_cm = 9'd30;
    e0 = echo_hi;
    pulse(12);
    wait_echo(1'b1, 100, ok);
    chk("s5_echo_up", int'(ok), 1);
    repeat (10) @(negedge clk);
    distancia_cm = 9'd90;
    wait_busy(1'b0, 500, ok);
    chk("s5_done", int'(ok), 1);
    chk("s5_echo_width", echo_hi - e0, 120);
    repeat (5) @(negedge clk);
    run_meas(12, ew, bw, roff, nr, ok);
    chk("s5_next_done", int'(ok), 1);
    chk("s5_next_echo", ew, 360);
    repeat (5) @(negedge clk);

    // 6: asynchronous reset mid-ECHO
    distancia_cm = 9'd25;
    pulse(12);
    wait_echo(1'b1, 100, ok);
    chk("s6_echo_up", int'(ok), 1);
    repeat (10) @(negedge clk);
    reset = 1'b1;
    #1;
    chk("s6_async_echo", int'(echo), 0);
    chk("s6_async_busy", int'(busy), 0);
    repeat (3) @(negedge clk);
    reset = 1'b0;
    distancia_cm = 9'd10;
    repeat (2) @(negedge clk);
    run_meas(12, ew, bw, roff, nr, ok);
    chk("s6_done", int'(ok), 1);
    chk("s6_echo", ew, 40);
    chk("s6_busy", bw, 110);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
